// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory port between I-fetch and D-access requesters; D wins ties unless I is starved.
// Latency: downstream request registered one cycle after grant; ok/read_data combinational from m_ok; upstream waits on ok (no credit).
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             i_req,
    input  logic             i_wreq,
    input  logic [WIDTH-1:0] i_addr,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [3:0]       i_wbyte,
    output logic [WIDTH-1:0] i_read_data,
    output logic             i_ok,

    input  logic             d_req,
    input  logic             d_wreq,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_write_data,
    input  logic [3:0]       d_wbyte,
    output logic [WIDTH-1:0] d_read_data,
    output logic             d_ok,

    output logic             m_req,
    output logic             m_wreq,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_write_data,
    output logic [3:0]       m_wbyte,
    input  logic [WIDTH-1:0] m_read_data,
    input  logic             m_ok,

    output logic             grant_i,
    output logic             grant_d
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_t;

    state_t            state_q;
    logic [SW-1:0]     streak_q;
    logic [SW-1:0]     streak_d;
    logic              m_req_q;
    logic              m_wreq_q;
    logic [WIDTH-1:0]  m_addr_q;
    logic [WIDTH-1:0]  m_write_data_q;
    logic [3:0]        m_wbyte_q;
    logic              grant_i_q;
    logic              grant_d_q;

    logic              i_forced;
    logic              pick_d;
    logic              pick_i;

    // With a zero limit the streak never moves off zero, so I is never forced.
    assign i_forced = (STARVE_LIMIT != 0) && (streak_q == STREAK_MAX);
    assign pick_d   = d_req && !(i_req && i_forced);
    assign pick_i   = i_req && !pick_d;

    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (pick_d) begin
                if (!i_req) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + SW'(1);
                end
            end else if (pick_i) begin
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            streak_q       <= '0;
            m_req_q        <= 1'b0;
            m_wreq_q       <= 1'b0;
            m_addr_q       <= '0;
            m_write_data_q <= '0;
            m_wbyte_q      <= '0;
            grant_i_q      <= 1'b0;
            grant_d_q      <= 1'b0;
        end else begin
            streak_q <= streak_d;
            case (state_q)
                IDLE: begin
                    if (pick_d) begin
                        state_q        <= D_BUSY;
                        grant_d_q      <= 1'b1;
                        m_req_q        <= 1'b1;
                        m_wreq_q       <= d_wreq;
                        m_addr_q       <= d_addr;
                        m_write_data_q <= d_write_data;
                        m_wbyte_q      <= d_wbyte;
                    end else if (pick_i) begin
                        state_q        <= I_BUSY;
                        grant_i_q      <= 1'b1;
                        m_req_q        <= 1'b1;
                        m_wreq_q       <= i_wreq;
                        m_addr_q       <= i_addr;
                        m_write_data_q <= i_write_data;
                        m_wbyte_q      <= i_wbyte;
                    end
                end
                // Always drop through IDLE so a completing owner cannot be regranted on its ok cycle.
                I_BUSY, D_BUSY: begin
                    if (m_ok) begin
                        state_q   <= IDLE;
                        m_req_q   <= 1'b0;
                        grant_i_q <= 1'b0;
                        grant_d_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_req_q   <= 1'b0;
                    grant_i_q <= 1'b0;
                    grant_d_q <= 1'b0;
                end
            endcase
        end
    end

    // A withdrawn owner still lets the downstream access finish, but sees no ok.
    assign i_ok         = (state_q == I_BUSY) && m_ok && i_req;
    assign d_ok         = (state_q == D_BUSY) && m_ok && d_req;
    assign i_read_data  = m_read_data;
    assign d_read_data  = m_read_data;

    assign m_req        = m_req_q;
    assign m_wreq       = m_wreq_q;
    assign m_addr       = m_addr_q;
    assign m_write_data = m_write_data_q;
    assign m_wbyte      = m_wbyte_q;
    assign grant_i      = grant_i_q;
    assign grant_d      = grant_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int W     = 32;
    localparam int LIMIT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_req, i_wreq, i_ok;
    logic [W-1:0] i_addr, i_write_data, i_read_data;
    logic [3:0]   i_wbyte;
    logic         d_req, d_wreq, d_ok;
    logic [W-1:0] d_addr, d_write_data, d_read_data;
    logic [3:0]   d_wbyte;
    logic         m_req, m_wreq, m_ok;
    logic [W-1:0] m_addr, m_write_data, m_read_data;
    logic [3:0]   m_wbyte;
    logic         grant_i, grant_d;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the port (0 none, 1 I, 2 D), what was latched, D-wins-while-I-waits count.
    int           mo_owner;
    int           mo_streak;
    logic         mo_wreq;
    logic [W-1:0] mo_addr, mo_wdata;
    logic [3:0]   mo_wbyte;
    logic         exp_i_ok, exp_d_ok;

    int i_gap, d_gap, mem_cnt;

    mem_port_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wreq(i_wreq), .i_addr(i_addr), .i_write_data(i_write_data),
        .i_wbyte(i_wbyte), .i_read_data(i_read_data), .i_ok(i_ok),
        .d_req(d_req), .d_wreq(d_wreq), .d_addr(d_addr), .d_write_data(d_write_data),
        .d_wbyte(d_wbyte), .d_read_data(d_read_data), .d_ok(d_ok),
        .m_req(m_req), .m_wreq(m_wreq), .m_addr(m_addr), .m_write_data(m_write_data),
        .m_wbyte(m_wbyte), .m_read_data(m_read_data), .m_ok(m_ok),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mo_owner  = 0;
        mo_streak = 0;
        mo_wreq   = 1'b0;
        mo_addr   = '0;
        mo_wdata  = '0;
        mo_wbyte  = '0;
    endtask

    task automatic model_edge();
        bit i_starved;
        if (rst) begin
            if (mo_owner == 0) begin
                i_starved = (LIMIT != 0) && (mo_streak == LIMIT);
                if (d_req && !(i_req && i_starved)) begin
                    mo_owner  = 2;
                    mo_wreq   = d_wreq;
                    mo_addr   = d_addr;
                    mo_wdata  = d_write_data;
                    mo_wbyte  = d_wbyte;
                    mo_streak = i_req ? ((mo_streak < LIMIT) ? mo_streak + 1 : LIMIT) : 0;
                end else if (i_req) begin
                    mo_owner  = 1;
                    mo_wreq   = i_wreq;
                    mo_addr   = i_addr;
                    mo_wdata  = i_write_data;
                    mo_wbyte  = i_wbyte;
                    mo_streak = 0;
                end
            end else if (m_ok) begin
                mo_owner = 0;
            end
        end
    endtask

    task automatic check_all();
        exp_i_ok = (mo_owner == 1) && m_ok && i_req;
        exp_d_ok = (mo_owner == 2) && m_ok && d_req;
        chk("m_req",   32'(m_req),   32'(mo_owner != 0));
        chk("grant_i", 32'(grant_i), 32'(mo_owner == 1));
        chk("grant_d", 32'(grant_d), 32'(mo_owner == 2));
        chk("i_ok",    32'(i_ok),    32'(exp_i_ok));
        chk("d_ok",    32'(d_ok),    32'(exp_d_ok));
        if (mo_owner != 0) begin
            chk("m_wreq",       32'(m_wreq),  32'(mo_wreq));
            chk("m_addr",       m_addr,       mo_addr);
            chk("m_write_data", m_write_data, mo_wdata);
            chk("m_wbyte",      32'(m_wbyte), 32'(mo_wbyte));
        end
        if (m_ok) begin
            chk("i_read_data", i_read_data, m_read_data);
            chk("d_read_data", d_read_data, m_read_data);
        end
    endtask

    task automatic settle();
        #3;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Both requesters already driven; completes n transactions and checks the grant order (2'b01=D, 2'b10=I).
    task automatic grant_seq(input int n, input logic [11:0] exp_seq, input string tag);
        for (int k = 0; k < n; k++) begin
            settle();
            advance();
            m_ok        = 1'b1;
            m_read_data = $urandom;
            settle();
            chk(tag, 32'({grant_i, grant_d}), 32'(exp_seq[2*k +: 2]));
            advance();
            m_ok = 1'b0;
        end
    endtask

    task automatic drive_random();
        if (!rst) begin
            rst = 1'b1;
        end else if ($urandom % 600 == 0) begin
            rst = 1'b0;
            model_reset();
        end
        if (i_req) begin
            if (exp_i_ok && ($urandom % 2 == 0)) begin
                i_req = 1'b0;
                i_gap = $urandom_range(0, 3);
            end else if (exp_i_ok || ($urandom % 8 == 0)) begin
                i_addr       = $urandom;
                i_write_data = $urandom;
            end else if ($urandom % 50 == 0) begin
                i_req = 1'b0;
            end
        end else if (i_gap > 0) begin
            i_gap--;
        end else if ($urandom % 3 == 0) begin
            i_req        = 1'b1;
            i_wreq       = ($urandom % 16 == 0);
            i_addr       = $urandom;
            i_write_data = $urandom;
            i_wbyte      = 4'($urandom);
        end
        if (d_req) begin
            if (exp_d_ok && ($urandom % 2 == 0)) begin
                d_req = 1'b0;
                d_gap = $urandom_range(0, 3);
            end else if (exp_d_ok || ($urandom % 8 == 0)) begin
                d_wreq       = $urandom % 2 == 0;
                d_addr       = $urandom;
                d_write_data = $urandom;
                d_wbyte      = 4'($urandom);
            end else if ($urandom % 50 == 0) begin
                d_req = 1'b0;
            end
        end else if (d_gap > 0) begin
            d_gap--;
        end else if ($urandom % 2 == 0) begin
            d_req        = 1'b1;
            d_wreq       = $urandom % 2 == 0;
            d_addr       = $urandom;
            d_write_data = $urandom;
            d_wbyte      = 4'($urandom);
        end
        if (m_ok) begin
            m_ok = 1'b0;
        end else if (mo_owner != 0) begin
            if (mem_cnt == 0) begin
                m_ok        = 1'b1;
                m_read_data = $urandom;
                mem_cnt     = $urandom_range(0, 3);
            end else begin
                mem_cnt--;
            end
        end else if ($urandom % 10 == 0) begin
            m_ok        = 1'b1;
            m_read_data = $urandom;
        end
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; i_wreq = 0; i_addr = '0; i_write_data = '0; i_wbyte = '0;
        d_req = 0; d_wreq = 0; d_addr = '0; d_write_data = '0; d_wbyte = '0;
        m_ok = 0; m_read_data = '0;
        i_gap = 0; d_gap = 0; mem_cnt = 0;
        exp_i_ok = 0; exp_d_ok = 0;
        model_reset();
        #2 rst = 1'b0;
        #10;
        chk("rst_m_req",        32'(m_req),   0);
        chk("rst_m_wreq",       32'(m_wreq),  0);
        chk("rst_m_addr",       m_addr,       0);
        chk("rst_m_write_data", m_write_data, 0);
        chk("rst_m_wbyte",      32'(m_wbyte), 0);
        chk("rst_grant_i",      32'(grant_i), 0);
        chk("rst_grant_d",      32'(grant_d), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single instruction fetch with a 3-cycle downstream latency.
        i_req = 1'b1; i_addr = 32'h2C; i_wbyte = 4'hF;
        settle(); chk("t1_mreq_before", 32'(m_req), 0); advance();
        settle(); chk("t1_mreq", 32'(m_req), 1); chk("t1_maddr", m_addr, 32'h2C);
        chk("t1_mwreq", 32'(m_wreq), 0); advance();
        settle(); advance();
        settle(); advance();
        m_ok = 1'b1; m_read_data = 32'h20080005;
        settle(); chk("t1_iok", 32'(i_ok), 1); chk("t1_rdata", i_read_data, 32'h20080005);
        chk("t1_dok", 32'(d_ok), 0); advance();
        m_ok = 1'b0; i_req = 1'b0;
        settle(); chk("t1_iok_pulse", 32'(i_ok), 0); advance();

        // Simultaneous requests: D write first, one idle cycle, then I.
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_wreq = 1'b1; d_addr = 32'h10; d_write_data = 32'hDEADBEEF; d_wbyte = 4'hF;
        settle(); advance();
        settle(); chk("t2_grant_d", 32'(grant_d), 1); chk("t2_mwreq", 32'(m_wreq), 1);
        chk("t2_wdata", m_write_data, 32'hDEADBEEF); chk("t2_maddr", m_addr, 32'h10); advance();
        m_ok = 1'b1;
        settle(); chk("t2_dok", 32'(d_ok), 1); chk("t2_iok", 32'(i_ok), 0); advance();
        m_ok = 1'b0; d_req = 1'b0; d_wreq = 1'b0;
        settle(); chk("t2_idle", 32'({grant_i, grant_d, m_req}), 0); advance();
        settle(); chk("t2_grant_i", 32'(grant_i), 1); chk("t2_iaddr", m_addr, 32'h40); advance();
        m_ok = 1'b1;
        settle(); chk("t2_iok2", 32'(i_ok), 1); advance();
        m_ok = 1'b0; i_req = 1'b0;
        settle(); advance();

        // Starvation limit 2 with both held: D,D,I,D,D,I.
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h50;
        grant_seq(6, 12'b10_01_01_10_01_01, "t3_order");
        i_req = 1'b0; d_req = 1'b0;
        settle(); advance();

        // I withdraws mid-transaction.
        i_req = 1'b1; i_addr = 32'h80;
        settle(); advance();
        i_req = 1'b0;
        settle(); chk("t4_grant_i", 32'(grant_i), 1); chk("t4_mreq_held", 32'(m_req), 1); advance();
        settle(); advance();
        m_ok = 1'b1;
        settle(); chk("t4_no_iok", 32'(i_ok), 0); chk("t4_mreq_ok", 32'(m_req), 1); advance();
        m_ok = 1'b0;
        settle(); chk("t4_idle", 32'({grant_i, m_req}), 0); advance();

        // Upstream address change while D in flight.
        d_req = 1'b1; d_wreq = 1'b0; d_addr = 32'h10;
        settle(); advance();
        d_addr = 32'h20;
        settle(); chk("t5_maddr_a", m_addr, 32'h10); advance();
        settle(); chk("t5_maddr_b", m_addr, 32'h10); advance();
        m_ok = 1'b1;
        settle(); chk("t5_maddr_c", m_addr, 32'h10); chk("t5_dok", 32'(d_ok), 1); advance();
        m_ok = 1'b0; d_req = 1'b0;
        settle(); advance();

        // Reset during D_BUSY with I waiting (streak nonzero), then a late m_ok.
        i_req = 1'b1; d_req = 1'b1; d_addr = 32'h30;
        settle(); advance();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        model_reset();
        settle(); chk("t6_mreq", 32'(m_req), 0); chk("t6_grant_d", 32'(grant_d), 0); advance();
        rst = 1'b1;
        settle(); advance();
        settle(); advance();
        m_ok = 1'b1; m_read_data = 32'h1234;
        settle(); chk("t6_late_dok", 32'(d_ok), 0); advance();
        m_ok = 1'b0;
        settle(); advance();
        i_req = 1'b1; d_req = 1'b1;
        grant_seq(3, 12'b000000_10_01_01, "t6_streak_cleared");
        i_req = 1'b0; d_req = 1'b0;
        settle(); advance();

        for (int c = 0; c < 4000; c++) begin
            drive_random();
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
